// File: rtl/hmmm_prog_loader.sv
// hmmm_prog_loader - serial program loader for the Hmmm core program memory.
//
// Deserialises the two-wire load stream into 8-bit address / 16-bit
// instruction writes, holds the core stopped while loading and releases it
// on a "go" command. Sticky framing / checksum / overrun error flags.
//
// Frame (synchronised samples): start (addr=1), 16 bits MSB first
// (addr line: address[7:0] then check[7:0]; data line: instruction[15:0]),
// stop (both lines 0). Go command in IDLE: addr=0, data=1.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   defined   - check byte must equal addr ^ data[15:8] ^ data[7:0]
//   undefined - check byte is ignored, err_check tied 0
//
// Parameters:
//   SYNC_STAGES  synchroniser flops per serial line (>= 2)
//   CNT_W        width of the saturating accepted-word counter
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pgrm_addr, pgrm_data    serial lines from pads (asynchronous)
//   mem_we/mem_ready        write request / accept handshake
//   mem_addr, mem_wdata     write address / instruction (stable while mem_we)
//   cpu_run                 1 = core may execute
//   loading                 FSM not in IDLE
//   words_loaded            accepted write count (saturating)
//   err_frame/err_check/err_overrun  sticky error flags
module hmmm_prog_loader #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pgrm_addr,
  input  logic             pgrm_data,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [7:0]       mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             cpu_run,
  output logic             loading,
  output logic [CNT_W-1:0] words_loaded,
  output logic             err_frame,
  output logic             err_check,
  output logic             err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_addr_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_a;
  logic                   w_d;

  logic [15:0]      r_asr;
  logic [15:0]      r_dsr;
  logic [3:0]       r_bitcnt;
  logic             r_mem_we;
  logic [7:0]       r_mem_addr;
  logic [15:0]      r_mem_wdata;
  logic             r_cpu_run;
  logic             r_run_req;
  logic [CNT_W-1:0] r_words;
  logic             r_err_frame;
  logic             r_err_overrun;

  logic w_start;
  logic w_go;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_check_ok;
  logic w_accept;
  logic w_frame_good;
  logic w_load;
  logic w_overrun;

  // Input synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_sync <= '0;
      r_data_sync <= '0;
    end else begin
      r_addr_sync <= {r_addr_sync[SYNC_STAGES-2:0], pgrm_addr};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], pgrm_data};
    end
  end

  assign w_a = r_addr_sync[SYNC_STAGES-1];
  assign w_d = r_data_sync[SYNC_STAGES-1];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and strobes
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_go       = 1'b0;
    w_stop_ok  = 1'b0;
    w_stop_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_a) begin
          w_start = 1'b1;
          w_next  = S_SHIFT;
        end else if (w_d) begin
          w_go = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == 4'd15) w_next = S_STOP;
      end
      S_STOP: begin
        // Stop cycle always returns to IDLE; a 1 here is a framing error,
        // never a new start bit.
        w_next = S_IDLE;
        if (w_a || w_d) w_stop_bad = 1'b1;
        else            w_stop_ok  = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic r_err_check;
  assign w_check_ok = (r_asr[7:0] == (r_asr[15:8] ^ r_dsr[15:8] ^ r_dsr[7:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_err_check <= 1'b0;
    else if (w_stop_ok && !w_check_ok)  r_err_check <= 1'b1;
  end

  assign err_check = r_err_check;
`else
  logic w_unused_check;
  assign w_check_ok     = 1'b1;
  assign w_unused_check = ^r_asr[7:0];
  assign err_check      = 1'b0;
`endif

  assign w_accept     = r_mem_we & mem_ready;
  assign w_frame_good = w_stop_ok & w_check_ok;
  // Holding register may be refilled in the same cycle it drains.
  assign w_load       = w_frame_good & (~r_mem_we | w_accept);
  assign w_overrun    = w_frame_good & r_mem_we & ~mem_ready;

  // Shift registers and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asr    <= '0;
      r_dsr    <= '0;
      r_bitcnt <= '0;
    end else if (w_start) begin
      r_bitcnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_asr    <= {r_asr[14:0], w_a};
      r_dsr    <= {r_dsr[14:0], w_d};
      r_bitcnt <= r_bitcnt + 4'd1;
    end
  end

  // Write holding register and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_words     <= '0;
    end else begin
      if (w_load) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_asr[15:8];
        r_mem_wdata <= r_dsr;
      end else if (w_accept) begin
        r_mem_we <= 1'b0;
      end
      if (w_accept && (r_words != '1)) r_words <= r_words + CNT_W'(1);
    end
  end

  // Run control: go request waits until no write is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_run <= 1'b0;
      r_run_req <= 1'b0;
    end else if (w_start) begin
      r_cpu_run <= 1'b0;
      r_run_req <= 1'b0;
    end else begin
      if (w_go) r_run_req <= 1'b1;
      if (r_run_req && !r_mem_we) begin
        r_cpu_run <= 1'b1;
        r_run_req <= 1'b0;
      end
    end
  end

  // Sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_frame   <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_stop_bad) r_err_frame   <= 1'b1;
      if (w_overrun)  r_err_overrun <= 1'b1;
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_run      = r_cpu_run;
  assign loading      = (r_state != S_IDLE);
  assign words_loaded = r_words;
  assign err_frame    = r_err_frame;
  assign err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_hmmm_prog_loader.sv
module tb_hmmm_prog_loader;

  localparam int SYNC  = 2;
  localparam int CNT_W = 9;
  localparam int LAT   = SYNC + 18;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pgrm_addr;
  logic             pgrm_data;
  logic             mem_we;
  logic             mem_ready;
  logic [7:0]       mem_addr;
  logic [15:0]      mem_wdata;
  logic             cpu_run;
  logic             loading;
  logic [CNT_W-1:0] words_loaded;
  logic             err_frame;
  logic             err_check;
  logic             err_overrun;

  hmmm_prog_loader #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pgrm_addr(pgrm_addr), .pgrm_data(pgrm_data),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .loading(loading),
    .words_loaded(words_loaded), .err_frame(err_frame),
    .err_check(err_check), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  chk_flip;
    bit          stop_a;
    bit          stop_d;
    bit          exp_we;
    bit          exp_ef;
    bit          exp_ec;
  } vec_t;

  wr_t  sbq[$];
  wr_t  w_exp;
  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = -1;
  int   we_cycles = 0;
  int   exp_words = 0;
  logic prev_we = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0] a, input logic [15:0] d);
    return a ^ d[15:8] ^ d[7:0];
  endfunction

  // Scoreboard: every accepted write is popped and compared
  always @(negedge clk) begin
    if (mem_we && !prev_we) rise_cyc = cyc;
    if (mem_we) we_cycles++;
    prev_we = mem_we;
    if (rst_n && mem_we && mem_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want none", mem_addr, mem_wdata);
      end else begin
        w_exp = sbq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w_exp.a));
        chk("wr_data", 32'(mem_wdata), 32'(w_exp.d));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pgrm_addr = 1'b0;
      pgrm_data = 1'b0;
    end
  endtask

  // Drives start, 16 bits and stop; abort_after>0 stops after that many bits.
  task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] c,
                            input bit sa, input bit sd, input int abort_after);
    logic [15:0] asr;
    asr = {a, c};
    @(posedge clk); #1;
    pgrm_addr = 1'b1;
    pgrm_data = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 16; i++) begin
      if (abort_after > 0 && i == abort_after) return;
      @(posedge clk); #1;
      pgrm_addr = asr[15-i];
      pgrm_data = d[15-i];
    end
    @(posedge clk); #1;
    pgrm_addr = sa;
    pgrm_data = sd;
  endtask

  task automatic go_cmd();
    @(posedge clk); #1;
    pgrm_addr = 1'b0;
    pgrm_data = 1'b1;
  endtask

  initial begin
    int w0;
    logic [7:0] c;
    vec_t v;

    vecs[0] = '{8'h05, 16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 16'hABCD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 16'hFFFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 16'h1234, 8'h07, 1'b0, 1'b0, !CHK_EN, 1'b0, CHK_EN};
    vecs[5] = '{8'h3C, 16'h5A5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, CHK_EN};
    vecs[6] = '{8'h3D, 16'h0F0F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, CHK_EN};
    vecs[7] = '{8'hFF, 16'hABCD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, CHK_EN};

    rst_n = 1'b0;
    pgrm_addr = 1'b0;
    pgrm_data = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_run", 32'(cpu_run), 0);
    chk("rst_loading", 32'(loading), 0);
    chk("rst_words", 32'(words_loaded), 0);
    chk("rst_errs", {29'd0, err_frame, err_check, err_overrun}, 0);
    rst_n = 1'b1;
    idle(4);

    // Table-driven frames, memory always ready
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      c = csum(v.addr, v.data) ^ v.chk_flip;
      rise_cyc = -1;
      w0 = we_cycles;
      if (v.exp_we) begin
        sbq.push_back('{a: v.addr, d: v.data});
        exp_words++;
      end
      send_frame(v.addr, v.data, c, v.stop_a, v.stop_d, 0);
      idle(LAT);
      if (v.exp_we) begin
        chk($sformatf("v%0d_latency", i), 32'(rise_cyc - start_cyc), 32'(LAT));
        chk($sformatf("v%0d_we_pulse", i), 32'(we_cycles - w0), 1);
      end else begin
        chk($sformatf("v%0d_no_we", i), 32'(we_cycles - w0), 0);
      end
      chk($sformatf("v%0d_err_frame", i), 32'(err_frame), 32'(v.exp_ef));
      chk($sformatf("v%0d_err_check", i), 32'(err_check), 32'(v.exp_ec));
      chk($sformatf("v%0d_err_overrun", i), 32'(err_overrun), 0);
      chk($sformatf("v%0d_words", i), 32'(words_loaded), 32'(exp_words));
      chk($sformatf("v%0d_loading", i), 32'(loading), 0);
      chk($sformatf("v%0d_sb_empty", i), 32'(sbq.size()), 0);
    end

    // Go command releases the core; a start bit stops it again
    go_cmd();
    idle(8);
    chk("go_run", 32'(cpu_run), 1);
    sbq.push_back('{a: 8'h42, d: 16'h1357});
    exp_words++;
    fork
      send_frame(8'h42, 16'h1357, csum(8'h42, 16'h1357), 1'b0, 1'b0, 0);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("run_before_start", 32'(cpu_run), 1);
        @(negedge clk);
        chk("run_after_start", 32'(cpu_run), 0);
        chk("loading_after_start", 32'(loading), 1);
      end
    join
    idle(LAT);
    chk("go_words", 32'(words_loaded), 32'(exp_words));

    // Overrun: memory stalled, two back-to-back frames
    mem_ready = 1'b0;
    sbq.push_back('{a: 8'h20, d: 16'h0BAD});
    send_frame(8'h20, 16'h0BAD, csum(8'h20, 16'h0BAD), 1'b0, 1'b0, 0);
    send_frame(8'h21, 16'h0C0D, csum(8'h21, 16'h0C0D), 1'b0, 1'b0, 0);
    idle(LAT);
    chk("ovr_we_held", 32'(mem_we), 1);
    chk("ovr_addr", 32'(mem_addr), 32'h20);
    chk("ovr_wdata", 32'(mem_wdata), 32'h0BAD);
    chk("ovr_err", 32'(err_overrun), 1);
    chk("ovr_words", 32'(words_loaded), 32'(exp_words));
    go_cmd();
    idle(6);
    chk("go_blocked_by_pending", 32'(cpu_run), 0);
    mem_ready = 1'b1;
    exp_words++;
    idle(5);
    chk("ovr_we_drained", 32'(mem_we), 0);
    chk("ovr_words_after", 32'(words_loaded), 32'(exp_words));
    chk("go_after_drain", 32'(cpu_run), 1);
    chk("ovr_sb_empty", 32'(sbq.size()), 0);

    // Reset in the middle of a frame
    send_frame(8'h77, 16'h4444, csum(8'h77, 16'h4444), 1'b0, 1'b0, 9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_wdata", 32'(mem_wdata), 0);
    chk("mid_rst_run", 32'(cpu_run), 0);
    chk("mid_rst_loading", 32'(loading), 0);
    chk("mid_rst_words", 32'(words_loaded), 0);
    chk("mid_rst_errs", {29'd0, err_frame, err_check, err_overrun}, 0);
    pgrm_addr = 1'b0;
    pgrm_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_words = 0;
    idle(4);
    chk("post_rst_no_we", 32'(mem_we), 0);
    sbq.push_back('{a: 8'h10, d: 16'h0001});
    exp_words++;
    send_frame(8'h10, 16'h0001, 8'h11, 1'b0, 1'b0, 0);
    idle(LAT);
    chk("post_rst_words", 32'(words_loaded), 32'(exp_words));
    chk("post_rst_errs", {29'd0, err_frame, err_check, err_overrun}, 0);

    chk("final_sb_empty", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
